// File: rtl/inst_loader.sv
// Boot loader: turns a framed serial byte stream into 16-bit instruction RAM writes and holds the CPU in reset until the load ends.
// Latency: a word's low byte accepted in cycle t is written in cycle t+1; done/error rise one cycle after the deciding byte.
// Backpressure: in_ready is decoded from state only; it drops during the write cycle and outside an active load.
module inst_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] remain_q, remain_d;   // words still to be written
    logic [15:0] addr_q, addr_d;       // byte address of the next write
    logic [7:0]  hi_q, hi_d;           // holds LEN_HI or a word's high byte
    logic [15:0] word_q, word_d;       // assembled word presented to the RAM
    logic [7:0]  csum_q, csum_d;       // XOR of every frame byte so far

    logic        xfer;
    logic [15:0] len_w;

    assign xfer  = in_valid && in_ready;
    assign len_w = {hi_q, in_data};

    // RAM port shows the registered address/word; strobes come from the WRITE state alone
    assign mem_addr = addr_q;
    assign mem_data = word_q;

    // Output decode from the current state only, so nothing follows in_valid/in_data combinationally
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
                in_ready = 1'b1;
            end
            S_WRITE: begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        cpu_hold = busy;
    end

    // Next-state and datapath update: frame parsing, word assembly, checksum and address stepping
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        word_d   = word_q;
        csum_d   = csum_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // done/error are the DONE/ERROR states, so leaving them clears both flags
                if (start) begin
                    state_d = S_LEN_HI;
                    csum_d  = 8'h00;
                    addr_d  = BASE_ADDR;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    csum_d   = csum_q ^ in_data;
                    remain_d = len_w;
                    if (len_w > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_w == 16'h0000) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // The word is only latched once both halves are in, so an aborted word never reaches RAM
                if (xfer) begin
                    word_d  = {hi_q, in_data};
                    csum_d  = csum_q ^ in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                remain_d = remain_q - 16'd1;
                addr_d   = addr_q + 16'd2;
                if (remain_q == 16'd1) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load and clears every output at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            remain_q <= 16'h0000;
            addr_q   <= 16'h0000;
            hi_q     <= 8'h00;
            word_q   <= 16'h0000;
            csum_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            word_q   <= word_d;
            csum_q   <= csum_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: frames are built from byte lists; expected writes and end status go into queues.
// A negedge monitor pops and compares whenever the DUT writes or ends a load.
// Driver applies inputs 1 time unit after the rising edge, with random gaps and stray start pulses.
module tb_inst_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [15:0] MAXW = 16'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [31:0] exp_wr[$];      // {addr, data}
    logic [1:0]  exp_end[$];     // {done, error}
    logic [15:0] words_q[$];
    int          frame_id  = 0;
    bit          cont_mode = 1'b0;
    longint      cyc = 0;

    inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_ce   (mem_ce),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    // Monitor: RAM writes and end-of-load status against the queued expectations
    int     mon_frame = -1;
    longint last_wr   = 0;
    logic   prev_busy = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        logic [1:0]  s;
        if (rst) begin
            if (mem_ce || mem_we) chk("ce_we_pair", {31'd0, mem_ce}, {31'd0, mem_we});
            if (mem_we) begin
                chk("ready_in_write", {31'd0, in_ready}, 32'd0);
                chk("hold_in_write", {31'd0, cpu_hold}, 32'd1);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {31'd0, mem_we}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, e[31:16]});
                    chk("wr_data", {16'd0, mem_data}, {16'd0, e[15:0]});
                end
                if (cont_mode && mon_frame == frame_id) chk("wr_spacing", 32'(cyc - last_wr), 32'd3);
                mon_frame = frame_id;
                last_wr   = cyc;
            end
            if (prev_busy && !busy) begin
                if (exp_end.size() == 0) begin
                    chk("unexpected_end", {30'd0, done, error}, 32'd0);
                end else begin
                    s = exp_end.pop_front();
                    chk("end_status", {30'd0, done, error}, {30'd0, s});
                end
            end
        end
        prev_busy = busy;
    end

    task automatic send_byte(input logic [7:0] b, input bit cont);
        int w;
        int g;
        if (!cont) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        if (!cont) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    // Reference model: frame = length, words high byte first, XOR checksum (optionally corrupted by mask)
    task automatic run_frame(input logic [15:0] n, input logic [7:0] mask, input bit cont);
        logic [7:0]  fb[$];
        logic [7:0]  x;
        logic [15:0] a;
        logic [1:0]  outcome;
        bit          over;
        over = (n > MAXW);
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        if (!over) begin
            for (int i = 0; i < int'(n); i++) begin
                fb.push_back(words_q[i][15:8]);
                fb.push_back(words_q[i][7:0]);
                a = BASE + 16'(2 * i);
                exp_wr.push_back({a, words_q[i]});
            end
            x = 8'h00;
            foreach (fb[i]) x = x ^ fb[i];
            fb.push_back(x ^ mask);
        end
        outcome = over ? 2'b01 : ((mask == 8'h00) ? 2'b10 : 2'b01);
        exp_end.push_back(outcome);
        frame_id++;
        cont_mode = cont;
        start = 1'b1;
        if (cont || $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            in_data  = fb[0];
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        foreach (fb[i]) send_byte(fb[i], cont);
        chk("end_timing", {30'd0, done, error}, {30'd0, outcome});
        if (over) chk("ready_after_err", {31'd0, in_ready}, 32'd0);
        chk("hold_released", {31'd0, cpu_hold}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_words(input int n);
        words_q = {};
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
    endtask

    initial begin
        logic [15:0] n;
        logic [7:0]  m;
        int          w;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {25'd0, in_ready, mem_ce, mem_we, busy, done, error, cpu_hold}, 32'd0);
        chk("reset_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_data", {16'd0, mem_data}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reference frame, good checksum 0x19 then corrupted to 0x18
        words_q = {16'h0169, 16'h0210, 16'h2141};
        run_frame(16'd3, 8'h00, 1'b0);
        run_frame(16'd3, 8'h01, 1'b0);
        // Empty image
        run_frame(16'd0, 8'h00, 1'b0);
        // Oversized length
        run_frame(16'h1001, 8'h00, 1'b0);
        // Continuous valid: 3-cycle word spacing
        words_q = {16'h0169, 16'h0210, 16'h2141};
        run_frame(16'd3, 8'h00, 1'b1);

        // Reset after the first word's high byte
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", {25'd0, in_ready, mem_ce, mem_we, busy, done, error, cpu_hold}, 32'd0);
        chk("midrst_addr", {16'd0, mem_addr}, 32'd0);
        chk("midrst_data", {16'd0, mem_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        words_q = {16'h0169, 16'h0210, 16'h2141};
        run_frame(16'd3, 8'h00, 1'b0);

        // Largest legal length, streamed back to back
        fill_words(int'(MAXW));
        run_frame(MAXW, 8'h00, 1'b1);

        // Random frames
        for (int k = 0; k < 16; k++) begin
            n = 16'($urandom_range(0, 8));
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fill_words(int'(n));
            run_frame(n, m, $urandom_range(0, 1) == 1);
        end
        n = 16'($urandom_range(32'h1001, 32'hFFFF));
        run_frame(n, 8'h00, 1'b0);

        w = 0;
        while ((exp_wr.size() != 0 || exp_end.size() != 0) && w < 20) begin
            w++;
            @(posedge clk);
        end
        #1;
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
        chk("ends_drained", 32'(exp_end.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the 16-bit instruction memory. It accepts a framed byte stream from the serial receiver and assembles the bytes into 16-bit instruction words. It writes those words into instruction RAM at consecutive even byte addresses and holds the CPU in reset until the image is complete. It is the write-side counterpart of the instruction fetch port, which later reads those words at addresses 0x0000, 0x0002, and so on.

## Interface
- `BASE_ADDR`, default 16'h0000: byte address of the first written word.
- `MAX_WORDS`, default 16'h1000: largest legal word count; a larger count is a framing error.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `mem_ce`  out  1  instruction RAM chip enable.
- `mem_we`  out  1  instruction RAM write enable.
- `mem_addr`  out  16  byte address of the write, always even.
- `mem_data`  out  16  instruction word to write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky: the last load completed with a good checksum.
- `error`  out  1  sticky: the last load failed.
- `cpu_hold`  out  1  keeps the CPU in reset while high.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: word count N, big-endian.
  - N words, each sent high byte first.
  - One checksum byte equal to the XOR of every preceding frame byte, including the length bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- Transitions:
  - IDLE/DONE/ERROR: `start` goes to LEN_HI. This clears `done`, `error` and the running checksum, and sets the address to `BASE_ADDR`.
  - LEN_HI: on a byte transfer, go to LEN_LO.
  - LEN_LO: on a byte transfer, choose by N:
    - N > `MAX_WORDS`: go to ERROR.
    - N = 0: go to CHECK.
    - Otherwise: go to DATA_HI.
  - DATA_HI: on a byte transfer, go to DATA_LO.
  - DATA_LO: on a byte transfer, go to WRITE.
  - WRITE: lasts one cycle. Decrement the remaining count and increment the address by 2. Go to CHECK if the remaining count reaches 0, else to DATA_HI.
  - CHECK: on a byte transfer, go to DONE if the byte equals the running XOR, else to ERROR.
- `in_ready` is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 everywhere else.
- `busy` and `cpu_hold` are 1 in every state except IDLE, DONE and ERROR.
- Address arithmetic is 16-bit and wraps modulo 2^16; there is no wrap detection.
- No partial write: if an error or reset occurs before a word's low byte is received, that word is never written.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 0, `mem_ce` = 0, `mem_we` = 0.
  - `mem_addr` = 0, `mem_data` = 0.
  - `busy` = 0, `done` = 0, `error` = 0, `cpu_hold` = 0.
- All outputs are registered or decoded from state only; none depend combinationally on `in_valid` or `in_data`.
- The transfer of a word's low byte in cycle t causes `mem_ce` = `mem_we` = 1 with a stable `mem_addr`/`mem_data` in cycle t+1, for exactly one cycle.
- Minimum rate is 3 cycles per word; the next byte can be accepted at t+2.
- `done` or `error` rises one cycle after the checksum byte transfer, or one cycle after the LEN_LO transfer when N exceeds `MAX_WORDS`.
- A `start` that arrives while `busy` is ignored.
- `start` asserted with `in_valid` in the same cycle: the byte is not consumed that cycle.
- Reset asserted mid-load: every output returns to its reset value immediately. The RAM keeps any words already written, and `cpu_hold` drops.

## Test plan
- Load N=3 with words 0169, 0210, 2141 and checksum 0x19. Required response:
  - Writes of 0x0169 at 0x0000, 0x0210 at 0x0002, 0x2141 at 0x0004.
  - `done` = 1, `error` = 0.
  - `cpu_hold` high from the cycle after `start` until `done`.
- Same frame with checksum 0x18: all three writes still occur, then `error` = 1 and `done` = 0.
- Load N=0 with checksum 0x00: no `mem_we` pulse, and `done` = 1 one cycle after the checksum byte.
- Length 0x1001 with the default `MAX_WORDS`: `error` = 1 one cycle after LEN_LO, no writes, and `in_ready` = 0.
- Hold `in_valid` = 1 continuously: `in_ready` = 0 during each WRITE cycle, no byte is lost or duplicated, and words land 3 cycles apart.
- Assert `rst` after the first word's high byte, then release and reload the full N=3 frame:
  - At reset, all outputs go to 0 at once and no write for that word occurs.
  - After the reload, the correct writes occur and `done` = 1.
